// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with programmable step, parallel load, wrap or
// saturate at the bounds, a terminal-count pulse and sticky overflow/underflow flags.
module updown_counter_mod #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 255,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              direction,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              sat_mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  counter_out,
  output logic              tc,
  output logic              ovf,
  output logic              unf
);

  // One extra bit lets the up-sum and the down-wrap sum be formed without loss.
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MAX_VAL + 1);

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH-1:0] next_cnt;
  logic             next_tc;
  logic             next_ovf;
  logic             next_unf;

  assign cnt_ext  = {1'b0, counter_out};
  assign step_ext = (WIDTH+1)'(step);
  assign load_ext = {1'b0, load_value};
  assign up_sum   = cnt_ext + step_ext;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    next_cnt = counter_out;
    next_tc  = 1'b0;
    next_ovf = ovf & ~clr_flags;
    next_unf = unf & ~clr_flags;

    if (load) begin
      next_cnt = (load_ext > MAX_EXT) ? WIDTH'(MAX_EXT) : load_value;
    end else if (enable && (step != '0)) begin
      if (direction) begin
        if (up_sum > MAX_EXT) begin
          next_tc  = 1'b1;
          next_ovf = 1'b1;
          next_cnt = sat_mode ? WIDTH'(MAX_EXT) : WIDTH'(up_sum - MOD_EXT);
        end else begin
          next_cnt = WIDTH'(up_sum);
        end
      end else begin
        if (step_ext > cnt_ext) begin
          next_tc  = 1'b1;
          next_unf = 1'b1;
          next_cnt = sat_mode ? '0 : WIDTH'(cnt_ext + MOD_EXT - step_ext);
        end else begin
          next_cnt = WIDTH'(cnt_ext - step_ext);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_out <= '0;
      tc          <= 1'b0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
    end else begin
      counter_out <= next_cnt;
      tc          <= next_tc;
      ovf         <= next_ovf;
      unf         <= next_unf;
    end
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench: three counter configurations driven by shared stimulus,
// compared each cycle with an arithmetic reference model plus directed checks.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable, direction, load, sat_mode, clr_flags;
  logic [3:0] step;
  logic [8:0] load_value;

  logic [3:0] cnt_a;
  logic [7:0] cnt_b;
  logic [8:0] cnt_c;
  logic       tc_a, ovf_a, unf_a;
  logic       tc_b, ovf_b, unf_b;
  logic       tc_c, ovf_c, unf_c;

  always #5 clk = ~clk;

  // A: small modulus (0..9), B: default 8-bit, C: 9-bit register capped at 255.
  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .STEP_W(3)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .direction(direction), .step(step[2:0]),
    .load(load), .load_value(load_value[3:0]), .sat_mode(sat_mode), .clr_flags(clr_flags),
    .counter_out(cnt_a), .tc(tc_a), .ovf(ovf_a), .unf(unf_a));

  updown_counter_mod dut_b (
    .clk(clk), .rst(rst), .enable(enable), .direction(direction), .step(step),
    .load(load), .load_value(load_value[7:0]), .sat_mode(sat_mode), .clr_flags(clr_flags),
    .counter_out(cnt_b), .tc(tc_b), .ovf(ovf_b), .unf(unf_b));

  updown_counter_mod #(.WIDTH(9), .MAX_VAL(255), .STEP_W(4)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .direction(direction), .step(step),
    .load(load), .load_value(load_value), .sat_mode(sat_mode), .clr_flags(clr_flags),
    .counter_out(cnt_c), .tc(tc_c), .ovf(ovf_c), .unf(unf_c));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the counting rules.
  int p_max[3]     = '{9, 255, 255};
  int p_stepmask[3] = '{7, 15, 15};
  int p_lvmask[3]   = '{15, 255, 511};
  int m_cnt[3], m_tc[3], m_ovf[3], m_unf[3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int st, lv;
      st = int'(step) & p_stepmask[i];
      lv = int'(load_value) & p_lvmask[i];
      m_tc[i] = 0;
      if (clr_flags) begin
        m_ovf[i] = 0;
        m_unf[i] = 0;
      end
      if (load) begin
        m_cnt[i] = (lv > p_max[i]) ? p_max[i] : lv;
      end else if (enable && st != 0) begin
        if (direction) begin
          if (m_cnt[i] + st > p_max[i]) begin
            m_tc[i] = 1; m_ovf[i] = 1;
            m_cnt[i] = sat_mode ? p_max[i] : (m_cnt[i] + st) % (p_max[i] + 1);
          end else begin
            m_cnt[i] = m_cnt[i] + st;
          end
        end else begin
          if (st > m_cnt[i]) begin
            m_tc[i] = 1; m_unf[i] = 1;
            m_cnt[i] = sat_mode ? 0 : m_cnt[i] - st + p_max[i] + 1;
          end else begin
            m_cnt[i] = m_cnt[i] - st;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    int oc[3], ot[3], oo[3], ou[3];
    oc = '{int'(cnt_a), int'(cnt_b), int'(cnt_c)};
    ot = '{int'(tc_a), int'(tc_b), int'(tc_c)};
    oo = '{int'(ovf_a), int'(ovf_b), int'(ovf_c)};
    ou = '{int'(unf_a), int'(unf_b), int'(unf_c)};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_cnt[%0d]", i), oc[i], m_cnt[i]);
      check($sformatf("model_tc[%0d]", i), ot[i], m_tc[i]);
      check($sformatf("model_ovf[%0d]", i), oo[i], m_ovf[i]);
      check($sformatf("model_unf[%0d]", i), ou[i], m_unf[i]);
    end
  endtask

  // Inputs change 1ns after an edge; the model steps with the values seen at the edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_idle();
    enable = 0; load = 0; clr_flags = 0; step = 0;
  endtask

  task automatic do_load(input int v);
    set_idle();
    load_value = 9'(v);
    load = 1;
    cycle();
    load = 0;
  endtask

  initial begin
    set_idle();
    direction = 1; sat_mode = 0; load_value = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1;

    // Asynchronous reset mid-count.
    do_load(35);
    enable = 1; direction = 1; step = 1;
    cycle(); cycle();
    check("t1_pre_rst_cnt", cnt_b, 37);
    #3 rst = 0;
    #1;
    model_reset();
    check("t1_rst_cnt_immediate", cnt_b, 0);
    check_all();
    @(posedge clk);
    #1 rst = 1;
    set_idle();
    repeat (5) cycle();
    check("t1_hold_cnt", cnt_b, 0);

    // Wrap up on MAX_VAL=9.
    sat_mode = 0;
    do_load(7);
    enable = 1; direction = 1; step = 2;
    cycle(); check("t2_a_9", cnt_a, 9); check("t2_a_tc0", tc_a, 0);
    cycle(); check("t2_a_1", cnt_a, 1); check("t2_a_tc1", tc_a, 1); check("t2_a_ovf", ovf_a, 1);
    cycle(); check("t2_a_3", cnt_a, 3); check("t2_a_tc_after", tc_a, 0); check("t2_a_ovf_sticky", ovf_a, 1);
    set_idle(); clr_flags = 1;
    cycle(); check("t2_a_ovf_clr", ovf_a, 0); check("t2_a_cnt_kept", cnt_a, 3);
    clr_flags = 0;

    // Wrap down on MAX_VAL=9.
    do_load(1);
    enable = 1; direction = 0; step = 3;
    cycle(); check("t3_a_8", cnt_a, 8); check("t3_a_tc", tc_a, 1); check("t3_a_unf", unf_a, 1);
    cycle(); check("t3_a_5", cnt_a, 5); check("t3_a_tc0", tc_a, 0);

    // Saturation on default parameters.
    sat_mode = 1;
    do_load(250);
    enable = 1; direction = 1; step = 4;
    cycle(); check("t4_b_254", cnt_b, 254); check("t4_b_tc0", tc_b, 0);
    cycle(); check("t4_b_255", cnt_b, 255); check("t4_b_tc1", tc_b, 1); check("t4_b_ovf", ovf_b, 1);
    cycle(); check("t4_b_hold", cnt_b, 255); check("t4_b_tc_again", tc_b, 1);
    do_load(10);
    enable = 1; direction = 0; step = 15;
    cycle(); check("t4_b_0", cnt_b, 0); check("t4_b_unf", unf_b, 1);

    // Load priority with clamp, then set-beats-clear.
    load_value = 9'd300; load = 1; enable = 1; direction = 1; step = 5;
    cycle(); check("t5_c_clamp", cnt_c, 255); check("t5_c_tc0", tc_c, 0);
    load = 0; clr_flags = 1; step = 1; sat_mode = 1;
    cycle(); check("t5_c_ovf_set_wins", ovf_c, 1); check("t5_c_tc", tc_c, 1);
    clr_flags = 0;

    // Zero step holds; wrap from 255 to 0.
    sat_mode = 0;
    do_load(128);
    enable = 1; step = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(); check("t6_b_hold128", cnt_b, 128); check("t6_b_no_tc", tc_b, 0);
    end
    do_load(255);
    enable = 1; direction = 1; step = 1;
    cycle(); check("t6_b_wrap0", cnt_b, 0); check("t6_b_tc", tc_b, 1);

    // Randomised traffic with occasional async reset.
    for (int n = 0; n < 600; n++) begin
      enable     = ($urandom_range(0, 3) != 0);
      direction  = 1'($urandom);
      step       = 4'($urandom);
      load       = ($urandom_range(0, 9) == 0);
      load_value = 9'($urandom);
      sat_mode   = ($urandom_range(0, 2) == 0);
      clr_flags  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1;
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised up/down counter replacing the fixed 8-bit counter.
- Adds:
  - configurable width and modulus
  - programmable step size
  - synchronous parallel load
  - wrap or saturate mode
  - terminal-count pulse
  - sticky overflow/underflow flags with clear
- Used as a general event/address counter in later exercises.
- All outputs are registered.

Parameters:
- WIDTH, 8: counter width in bits; must be at least 2.
- MAX_VAL, 255: highest count value. Count range is 0..MAX_VAL. Must satisfy MAX_VAL ≤ 2**WIDTH-1.
- STEP_W, 4: width of the step input. Must satisfy 2**STEP_W-1 ≤ MAX_VAL, so one wrap correction always suffices.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, active-low, asynchronous assert; clears all state while low
- enable  in  1  when 1, count by step this cycle
- direction  in  1  1 = count up, 0 = count down
- step  in  STEP_W  increment/decrement magnitude; 0 = no change
- load  in  1  synchronous load strobe
- load_value  in  WIDTH  value loaded when load=1
- sat_mode  in  1  1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1
- clr_flags  in  1  synchronous clear of ovf/unf sticky flags
- counter_out  out  WIDTH  current count
- tc  out  1  one-cycle pulse: boundary crossed or clamped this update
- ovf  out  1  sticky: an up-count exceeded MAX_VAL
- unf  out  1  sticky: a down-count went below 0

Behaviour:
- Reset: rst=0 asynchronously forces counter_out=0, tc=0, ovf=0, unf=0. Takes effect immediately, including mid-count. The first update occurs on the first rising clk edge after rst returns to 1.
- Priority per rising edge: rst > load > enable. With enable=0 and load=0, counter_out holds.

Load:
- counter_out <= min(load_value, MAX_VAL).
- tc=0 for that update; flags unchanged.
- A load while enable=1 ignores the count.

Count (enable=1, load=0):
- All arithmetic uses WIDTH+1 bits internally.
- Up, counter_out + step ≤ MAX_VAL: counter_out <= counter_out + step.
- Up, counter_out + step > MAX_VAL:
  - wrap: counter_out <= counter_out + step - (MAX_VAL+1)
  - saturate: counter_out <= MAX_VAL
  - Either mode: tc=1 for one cycle, ovf set.
- Down, step ≤ counter_out: counter_out <= counter_out - step.
- Down, step > counter_out:
  - wrap: counter_out <= counter_out + (MAX_VAL+1) - step
  - saturate: counter_out <= 0
  - Either mode: tc=1 for one cycle, unf set.
- step=0: counter_out holds, tc=0, flags unchanged.
- Already saturated at a bound and pushed further (e.g. at MAX_VAL, up, step>0): value holds, and tc pulses and ovf sets again on every such cycle.

Latency and timing:
- tc is registered and asserted in the same cycle counter_out first shows the post-event value.
- tc is 0 on every other cycle.

Flags:
- ovf/unf stay set until clr_flags=1 or reset.
- If clr_flags and a new set event occur on the same edge, set wins.
- clr_flags does not affect counter_out or tc.

Mode changes:
- sat_mode and direction may change on any cycle.
- The value sampled at the edge applies; there is no internal state beyond counter_out and the flags.

Test Plan:
1. Reset/hold: drive rst=0 mid-count at counter_out=37 → counter_out=0, tc=ovf=unf=0 immediately, not at the next edge. After release, with enable=0 for 5 cycles → counter_out stays 0.
2. Wrap up (MAX_VAL=9, WIDTH=4, sat_mode=0): load 7, then up, step=2, three cycles → 9, 1 (tc=1, ovf=1), 3 (tc=0). ovf stays 1 until clr_flags pulse, then 0.
3. Wrap down (MAX_VAL=9): load 1, then down, step=3 → 8 with tc=1, unf=1. Next step=3 → 5, tc=0.
4. Saturate (default params, sat_mode=1): load 250, then up, step=4, three cycles → 254, 255 (tc=1, ovf=1), 255 (tc=1 again). Then down, step=15 from load 10 → 0 with unf=1.
5. Priority/clamp: load=1 with load_value=300 on WIDTH=9, MAX_VAL=255, enable=1 → counter_out=255, tc=0. clr_flags=1 on the same edge as an overflow → ovf ends at 1.
6. Step zero and default width: enable=1, step=0 for 4 cycles at 128 → holds 128, no tc. Default params, up, step=1 from 255 in wrap mode → 0, tc=1.
